// File: rtl/cpu_param_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, addressing modes and FSM states.
// Also holds small opcode-classification helpers used by the datapath and bus logic.
package cpu_param_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_STA = 4'h1,
    OP_LDA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_NOT = 4'h7,
    OP_J   = 4'h8,
    OP_JN  = 4'h9,
    OP_JZ  = 4'hA,
    OP_IN  = 4'hB,
    OP_OUT = 4'hC,
    OP_SHR = 4'hD,
    OP_SHL = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    MODE_DIR  = 2'b00,
    MODE_IND  = 2'b01,
    MODE_IM   = 2'b10,
    MODE_NONE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPND   = 3'd2,
    S_INDIR  = 3'd3,
    S_EXEC   = 3'd4,
    S_IO_IN  = 3'd5,
    S_IO_OUT = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Opcodes whose data operand comes from memory (or the immediate word).
  function automatic logic is_alu_read(opcode_t op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic writes_carry(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHR) || (op == OP_SHL);
  endfunction

  function automatic logic is_jump(opcode_t op);
    return (op == OP_J) || (op == OP_JN) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/cpu_param_if.sv
// Memory bus between the CPU (master) and its memory (slave).
// Handshake: master raises mem_req with mem_addr/mem_we/mem_wdata held stable until it
// samples mem_ack=1 on a rising edge; mem_rdata is valid in that same cycle. The master
// then drops mem_req for at least one cycle, and ignores mem_ack while mem_req is low.
interface cpu_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cpu_param_ula.sv
// Combinational ALU: result plus N/Z/C for the accumulator CPU.
// C is meaningful only for ADD, SUB (no-borrow), SHR and SHL; the caller decides what to commit.
module ula_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              n_o,
  output logic              z_o,
  output logic              c_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = '0;
    res_o = a_i;
    c_o   = 1'b0;
    case (op_i)
      OP_LDA: res_o = b_i;
      OP_ADD: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res_o = sum[DATA_W-1:0];
        c_o   = sum[DATA_W];
      end
      // Two's-complement subtract; carry-out is the no-borrow flag.
      OP_SUB: begin
        sum   = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
        res_o = sum[DATA_W-1:0];
        c_o   = sum[DATA_W];
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_NOT: res_o = ~a_i;
      OP_SHR: begin
        res_o = {1'b0, a_i[DATA_W-1:1]};
        c_o   = a_i[0];
      end
      OP_SHL: begin
        res_o = {a_i[DATA_W-2:0], 1'b0};
        c_o   = a_i[DATA_W-1];
      end
      default: ;
    endcase
  end

  assign n_o = res_o[DATA_W-1];
  assign z_o = (res_o == '0);

endmodule

// File: rtl/cpu_param.sv
// Parametrised accumulator CPU: multi-cycle FSM over a req/ack memory bus, IN/OUT
// valid/ready ports, and observation outputs (AC, PC, flags, halted, FSM state).
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_param_if.master       mem,
  input  logic [DATA_W-1:0] entrada,
  input  logic              entrada_valid,
  output logic              entrada_ready,
  output logic [DATA_W-1:0] saida,
  output logic              saida_valid,
  input  logic              saida_ready,
  output logic [DATA_W-1:0] acumulador,
  output logic [ADDR_W-1:0] qPC,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  opcode_t           ri_op_q, ri_op_d;
  mode_t             ri_mode_q, ri_mode_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0] saida_q, saida_d;
  logic              saida_valid_q, saida_valid_d;
  logic              gap_q;

  logic              is_imm;
  logic              mem_active;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic              xfer_done;

  opcode_t           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_n, alu_z, alu_c;
  logic              alu_commit;
  logic              jump_taken;

  assign is_imm = (ri_mode_q == MODE_IM) || (ri_mode_q == MODE_NONE);

  // Which states need a bus transfer, and with what address/direction.
  always_comb begin
    mem_active = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = pc_q;
    case (state_q)
      S_FETCH, S_OPND: mem_active = 1'b1;
      S_INDIR: begin
        mem_active = 1'b1;
        bus_addr   = opnd_q[ADDR_W-1:0];
      end
      S_EXEC: begin
        bus_addr = ea_q;
        if (!is_imm && (is_alu_read(ri_op_q) || (ri_op_q == OP_STA))) begin
          mem_active = 1'b1;
          bus_we     = (ri_op_q == OP_STA);
        end
      end
      default: ;
    endcase
  end

  // gap_q forces the idle cycle after every completed transfer and masks mem_req in reset.
  assign mem.mem_req   = mem_active && !gap_q;
  assign mem.mem_we    = mem.mem_req && bus_we;
  assign mem.mem_addr  = bus_addr;
  assign mem.mem_wdata = ac_q;
  assign xfer_done     = mem.mem_req && mem.mem_ack;

  always_comb begin
    alu_op = ri_op_q;
    alu_b  = is_imm ? opnd_q : mem.mem_rdata;
    if (state_q == S_IO_IN) begin
      alu_op = OP_LDA;
      alu_b  = entrada;
    end
  end

  ula_param #(.DATA_W(DATA_W)) u_ula (
    .op_i  (alu_op),
    .a_i   (ac_q),
    .b_i   (alu_b),
    .res_o (alu_res),
    .n_o   (alu_n),
    .z_o   (alu_z),
    .c_o   (alu_c)
  );

  always_comb begin
    case (ri_op_q)
      OP_J:    jump_taken = 1'b1;
      OP_JN:   jump_taken = n_q;
      OP_JZ:   jump_taken = z_q;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ac_d          = ac_q;
    ri_op_d       = ri_op_q;
    ri_mode_d     = ri_mode_q;
    opnd_d        = opnd_q;
    ea_d          = ea_q;
    n_d           = n_q;
    z_d           = z_q;
    c_d           = c_q;
    saida_d       = saida_q;
    saida_valid_d = saida_valid_q;
    alu_commit    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (xfer_done) begin
          ri_op_d   = opcode_t'(mem.mem_rdata[DATA_W-1 -: OPCODE_W]);
          ri_mode_d = mode_t'(mem.mem_rdata[1:0]);
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ri_op_q)
          OP_NOP: state_d = S_FETCH;
          OP_NOT, OP_SHR, OP_SHL: begin
            alu_commit = 1'b1;
            state_d    = S_FETCH;
          end
          OP_HLT: state_d = S_HALT;
          OP_IN:  state_d = S_IO_IN;
          OP_OUT: begin
            saida_d       = ac_q;
            saida_valid_d = 1'b1;
            state_d       = S_IO_OUT;
          end
          default: state_d = S_OPND;
        endcase
      end
      S_OPND: begin
        if (xfer_done) begin
          opnd_d  = mem.mem_rdata;
          ea_d    = mem.mem_rdata[ADDR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (ri_mode_q == MODE_IND) ? S_INDIR : S_EXEC;
        end
      end
      S_INDIR: begin
        if (xfer_done) begin
          ea_d    = mem.mem_rdata[ADDR_W-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_jump(ri_op_q)) begin
          if (jump_taken) pc_d = ea_q;
          state_d = S_FETCH;
        end else if (is_alu_read(ri_op_q)) begin
          if (is_imm || xfer_done) begin
            alu_commit = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (ri_op_q == OP_STA) begin
          if (is_imm || xfer_done) state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_IO_IN: begin
        if (entrada_valid) begin
          alu_commit = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_IO_OUT: begin
        if (saida_valid_q && saida_ready) begin
          saida_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (alu_commit) begin
      ac_d = alu_res;
      n_d  = alu_n;
      z_d  = alu_z;
      if (writes_carry(alu_op)) c_d = alu_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      ac_q          <= '0;
      ri_op_q       <= OP_NOP;
      ri_mode_q     <= MODE_DIR;
      opnd_q        <= '0;
      ea_q          <= '0;
      n_q           <= 1'b0;
      z_q           <= 1'b1;
      c_q           <= 1'b0;
      saida_q       <= '0;
      saida_valid_q <= 1'b0;
      gap_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ac_q          <= ac_d;
      ri_op_q       <= ri_op_d;
      ri_mode_q     <= ri_mode_d;
      opnd_q        <= opnd_d;
      ea_q          <= ea_d;
      n_q           <= n_d;
      z_q           <= z_d;
      c_q           <= c_d;
      saida_q       <= saida_d;
      saida_valid_q <= saida_valid_d;
      gap_q         <= xfer_done;
    end
  end

  assign entrada_ready = (state_q == S_IO_IN);
  assign saida         = saida_q;
  assign saida_valid   = saida_valid_q;
  assign acumulador    = ac_q;
  assign qPC           = pc_q;
  assign flag_n        = n_q;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
  assign halted        = (state_q == S_HALT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: a 16/8-bit instance and an 8/4-bit instance, each with
// its own behavioural memory; directed programs with hand-computed results.
module tb_cpu_param;
  import cpu_param_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst16_n, rst8_n;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT 16/8 ----------------
  cpu_param_if #(.DATA_W(16), .ADDR_W(8)) m16 ();
  logic [15:0] entrada16, saida16, ac16;
  logic        entrada_valid16, entrada_ready16, saida_valid16, saida_ready16;
  logic [7:0]  pc16;
  logic        n16, z16, c16, halted16;
  state_t      st16;

  cpu_param #(.DATA_W(16), .ADDR_W(8)) u16 (
    .clk(clk), .rst_n(rst16_n), .mem(m16.master),
    .entrada(entrada16), .entrada_valid(entrada_valid16), .entrada_ready(entrada_ready16),
    .saida(saida16), .saida_valid(saida_valid16), .saida_ready(saida_ready16),
    .acumulador(ac16), .qPC(pc16), .flag_n(n16), .flag_z(z16), .flag_c(c16),
    .halted(halted16), .dbg_state(st16)
  );

  // ---------------- DUT 8/4 ----------------
  cpu_param_if #(.DATA_W(8), .ADDR_W(4)) m8 ();
  logic [7:0] entrada8, saida8, ac8;
  logic       entrada_valid8, entrada_ready8, saida_valid8, saida_ready8;
  logic [3:0] pc8;
  logic       n8, z8, c8, halted8;
  state_t     st8;

  cpu_param #(.DATA_W(8), .ADDR_W(4)) u8 (
    .clk(clk), .rst_n(rst8_n), .mem(m8.master),
    .entrada(entrada8), .entrada_valid(entrada_valid8), .entrada_ready(entrada_ready8),
    .saida(saida8), .saida_valid(saida_valid8), .saida_ready(saida_ready8),
    .acumulador(ac8), .qPC(pc8), .flag_n(n8), .flag_z(z8), .flag_c(c8),
    .halted(halted8), .dbg_state(st8)
  );

  // ---------------- memory models ----------------
  logic [15:0] mem16 [256];
  logic [7:0]  mem8  [16];
  int   dly16 = 0;
  int   cnt16 = 0;
  logic inj16 = 1'b0;

  always @(posedge clk) begin
    m16.mem_ack <= inj16;
    if (m16.mem_req && !m16.mem_ack) begin
      if (cnt16 >= dly16) begin
        m16.mem_ack <= 1'b1;
        cnt16 <= 0;
        if (m16.mem_we) mem16[m16.mem_addr] = m16.mem_wdata;
        else            m16.mem_rdata <= mem16[m16.mem_addr];
      end else begin
        cnt16 <= cnt16 + 1;
      end
    end else if (!m16.mem_req) begin
      cnt16 <= 0;
    end
  end

  always @(posedge clk) begin
    m8.mem_ack <= 1'b0;
    if (m8.mem_req && !m8.mem_ack) begin
      m8.mem_ack <= 1'b1;
      if (m8.mem_we) mem8[m8.mem_addr] = m8.mem_wdata;
      else           m8.mem_rdata <= mem8[m8.mem_addr];
    end
  end

  // ---------------- bus / handshake monitors ----------------
  logic       prev_req16 = 1'b0, prev_ack16 = 1'b0, prev_rst16 = 1'b0;
  logic [7:0] prev_addr16 = '0;
  int unstable16 = 0, gapviol16 = 0, hs16 = 0, req_seen16 = 0;
  logic [3:0] log8 [$];

  always @(posedge clk) begin
    if (rst16_n && prev_rst16 && prev_req16) begin
      if (!prev_ack16 && m16.mem_req && (m16.mem_addr !== prev_addr16)) unstable16++;
      if (prev_ack16 && m16.mem_req) gapviol16++;
    end
    if (saida_valid16 && saida_ready16) hs16++;
    if (m16.mem_req) req_seen16++;
    if (m8.mem_req && m8.mem_ack) log8.push_back(m8.mem_addr);
    prev_req16  <= m16.mem_req;
    prev_ack16  <= m16.mem_ack;
    prev_addr16 <= m16.mem_addr;
    prev_rst16  <= rst16_n;
  end

  // ---------------- scoreboard helpers ----------------
  logic [3:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins16(opcode_t op, logic [1:0] mode);
    return {op, 10'b0, mode};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold16();
    @(negedge clk);
    rst16_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem16[i] = '0;
  endtask

  task automatic start16();
    @(negedge clk);
    rst16_n = 1'b1;
  endtask

  task automatic wait_halt16(input string tag);
    int n = 0;
    while (!halted16 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, halted16, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, snap, snap2, vcnt, n;
    rst16_n = 1'b1; rst8_n = 1'b1;
    entrada16 = '0; entrada_valid16 = 1'b0; saida_ready16 = 1'b0;
    entrada8 = '0; entrada_valid8 = 1'b0; saida_ready8 = 1'b0;
    for (int i = 0; i < 256; i++) mem16[i] = '0;
    for (int i = 0; i < 16; i++) mem8[i] = '0;
    #2 rst16_n = 1'b0; rst8_n = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_ac", ac16, 16'h0);
    chk("rst_pc", pc16, 8'h0);
    chk("rst_n", n16, 1'b0);
    chk("rst_z", z16, 1'b1);
    chk("rst_c", c16, 1'b0);
    chk("rst_req", m16.mem_req, 1'b0);
    chk("rst_we", m16.mem_we, 1'b0);
    chk("rst_in_ready", entrada_ready16, 1'b0);
    chk("rst_saida", saida16, 16'h0);
    chk("rst_saida_valid", saida_valid16, 1'b0);
    chk("rst_halted", halted16, 1'b0);
    chk("rst_state", st16, S_FETCH);

    // LDA DIR 10 (7) ; ADD IM FFFA ; HLT
    mem16[0] = ins16(OP_LDA, MODE_DIR); mem16[1] = 16'd10;
    mem16[2] = ins16(OP_ADD, MODE_IM);  mem16[3] = 16'hFFFA;
    mem16[4] = ins16(OP_HLT, MODE_NONE); mem16[10] = 16'd7;
    start16();
    wait_halt16("add_halt");
    chk("add_ac", ac16, 16'h0001);
    chk("add_c", c16, 1'b1);
    chk("add_z", z16, 1'b0);
    chk("add_pc", pc16, 8'd5);
    snap = req_seen16;
    cyc(10);
    chk("halt_no_req", req_seen16 - snap, 0);
    chk("halt_stays", halted16, 1'b1);

    // LDA IM 3 ; SUB IM 5 ; JZ 30 (not taken) ; JN 20 (taken) ; HLT@20
    hold16();
    mem16[0] = ins16(OP_LDA, MODE_IM);  mem16[1] = 16'd3;
    mem16[2] = ins16(OP_SUB, MODE_IM);  mem16[3] = 16'd5;
    mem16[4] = ins16(OP_JZ, MODE_DIR);  mem16[5] = 16'd30;
    mem16[6] = ins16(OP_JN, MODE_DIR);  mem16[7] = 16'd20;
    mem16[8] = ins16(OP_HLT, MODE_NONE);
    mem16[20] = ins16(OP_HLT, MODE_NONE);
    mem16[30] = ins16(OP_HLT, MODE_NONE);
    start16();
    wait_halt16("sub_halt");
    chk("sub_ac", ac16, 16'hFFFE);
    chk("sub_n", n16, 1'b1);
    chk("sub_c", c16, 1'b0);
    chk("jn_pc", pc16, 8'd21);

    // LDA IM 0F0E ; AND IM 00FF ; OR DIR 90 (F000) ; NOT ; SHR ; HLT
    hold16();
    mem16[0] = ins16(OP_LDA, MODE_IM);  mem16[1] = 16'h0F0E;
    mem16[2] = ins16(OP_AND, MODE_IM);  mem16[3] = 16'h00FF;
    mem16[4] = ins16(OP_OR, MODE_DIR);  mem16[5] = 16'd90;
    mem16[6] = ins16(OP_NOT, MODE_DIR);
    mem16[7] = ins16(OP_SHR, MODE_IND);
    mem16[8] = ins16(OP_HLT, MODE_NONE);
    mem16[90] = 16'hF000;
    start16();
    wait_halt16("logic_halt");
    chk("logic_ac", ac16, 16'h07F8);
    chk("shr_c", c16, 1'b1);
    chk("logic_pc", pc16, 8'd9);

    // LDA IM 5A5A ; STA DIR 50 ; STA IND 60 (->70) ; STA IM 80 (no write) ; HLT
    hold16();
    mem16[0] = ins16(OP_LDA, MODE_IM);  mem16[1] = 16'h5A5A;
    mem16[2] = ins16(OP_STA, MODE_DIR); mem16[3] = 16'd50;
    mem16[4] = ins16(OP_STA, MODE_IND); mem16[5] = 16'd60;
    mem16[6] = ins16(OP_STA, MODE_IM);  mem16[7] = 16'd80;
    mem16[8] = ins16(OP_HLT, MODE_NONE);
    mem16[60] = 16'd70; mem16[80] = 16'h1111;
    start16();
    wait_halt16("sta_halt");
    chk("sta_dir", mem16[50], 16'h5A5A);
    chk("sta_ind", mem16[70], 16'h5A5A);
    chk("sta_im_nowrite", mem16[80], 16'h1111);

    // LDA IND 30 (->40 = 1234), with and without slow acks
    for (int d = 0; d < 4; d += 3) begin
      hold16();
      dly16 = d;
      mem16[0] = ins16(OP_LDA, MODE_IND); mem16[1] = 16'd30;
      mem16[2] = ins16(OP_HLT, MODE_NONE);
      mem16[30] = 16'd40; mem16[40] = 16'h1234;
      snap = unstable16; snap2 = gapviol16;
      start16();
      wait_halt16("ind_halt");
      chk("ind_ac", ac16, 16'h1234);
      chk("ind_addr_stable", unstable16 - snap, 0);
      chk("ind_req_gap", gapviol16 - snap2, 0);
    end
    dly16 = 0;

    // IN (valid 5 cycles late) ; OUT (ready low 4 cycles) ; HLT
    hold16();
    mem16[0] = ins16(OP_IN, MODE_DIR);
    mem16[1] = ins16(OP_OUT, MODE_IM);
    mem16[2] = ins16(OP_HLT, MODE_NONE);
    start16();
    n = 0;
    while (!entrada_ready16 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready", entrada_ready16, 1'b1);
    entrada16 = 16'h5555;
    cyc(5);
    chk("in_wait_ac", ac16, 16'h0);
    chk("in_wait_ready", entrada_ready16, 1'b1);
    entrada16 = 16'h00AA; entrada_valid16 = 1'b1;
    @(negedge clk);
    entrada_valid16 = 1'b0; entrada16 = '0;
    chk("in_ac", ac16, 16'h00AA);
    chk("in_ready_drop", entrada_ready16, 1'b0);
    n = 0;
    while (!saida_valid16 && n < 50) begin @(negedge clk); n++; end
    chk("out_valid", saida_valid16, 1'b1);
    chk("out_data", saida16, 16'h00AA);
    snap = hs16;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (saida_valid16) vcnt++;
    end
    chk("out_valid_held", vcnt, 4);
    saida_ready16 = 1'b1;
    @(negedge clk);
    saida_ready16 = 1'b0;
    chk("out_valid_drop", saida_valid16, 1'b0);
    wait_halt16("io_halt");
    chk("out_single_hs", hs16 - snap, 1);
    chk("out_hold", saida16, 16'h00AA);

    // reset during OPND with a pending slow transfer, then a stray ack
    hold16();
    dly16 = 3;
    mem16[0] = ins16(OP_LDA, MODE_DIR); mem16[1] = 16'd10;
    mem16[2] = ins16(OP_HLT, MODE_NONE); mem16[10] = 16'h0042;
    start16();
    n = 0;
    while (!(st16 == S_OPND && m16.mem_req) && n < 50) begin @(negedge clk); n++; end
    chk("opnd_reached", (st16 == S_OPND) && m16.mem_req, 1'b1);
    #2 rst16_n = 1'b0;
    #1;
    chk("mid_rst_state", st16, S_FETCH);
    chk("mid_rst_pc", pc16, 8'd0);
    chk("mid_rst_req", m16.mem_req, 1'b0);
    chk("mid_rst_we", m16.mem_we, 1'b0);
    chk("mid_rst_z", z16, 1'b1);
    chk("mid_rst_halted", halted16, 1'b0);
    @(negedge clk);
    inj16 = 1'b1;
    @(negedge clk);
    rst16_n = 1'b1; inj16 = 1'b0;
    @(negedge clk);
    chk("late_ack_state", st16, S_FETCH);
    chk("late_ack_pc", pc16, 8'd0);
    chk("first_req", m16.mem_req, 1'b1);
    chk("first_addr", m16.mem_addr, 8'd0);
    chk("first_we", m16.mem_we, 1'b0);
    wait_halt16("post_rst_halt");
    chk("post_rst_ac", ac16, 16'h0042);
    dly16 = 0;

    // 8/4: J 15 ; NOP@15 ; fetch wraps to 0
    mem8[0] = 8'h80; mem8[1] = 8'h0F; mem8[15] = 8'h00;
    base = log8.size();
    @(negedge clk);
    rst8_n = 1'b1;
    n = 0;
    while (log8.size() < base + 6 && n < 200) begin @(negedge clk); n++; end
    chk("wrap_log_len", log8.size() >= base + 6, 1'b1);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd15);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd15);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      if (log8.size() > base + i) chk("wrap_addr", log8[base + i], e);
    end

    // 8/4: LDA IM 81 ; SHL ; HLT
    rst8_n = 1'b0;
    @(negedge clk);
    mem8[0] = 8'h22; mem8[1] = 8'h81; mem8[2] = 8'hE0; mem8[3] = 8'hF0;
    rst8_n = 1'b1;
    n = 0;
    while (!halted8 && n < 100) begin @(negedge clk); n++; end
    chk("shl_halt", halted8, 1'b1);
    chk("shl_ac", ac8, 8'h02);
    chk("shl_c", c8, 1'b1);
    chk("shl_n", n8, 1'b0);

    chk("bus_addr_stable_all", unstable16, 0);
    chk("bus_req_gap_all", gapviol16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
